// File: rtl/pll_drp_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : pll_drp_pkg
// Brief  : Shared types, DRP register map and divide encoder for the PLL
//          DRP reconfiguration master.
// Rev    : 1.0 - initial release
// ============================================================================
package pll_drp_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_ASSERT_RST = 4'd1,
    S_RD         = 4'd2,
    S_RD_WAIT    = 4'd3,
    S_WR         = 4'd4,
    S_WR_WAIT    = 4'd5,
    S_NEXT       = 4'd6,
    S_HOLD       = 4'd7,
    S_RELEASE    = 4'd8,
    S_WAIT_LOCK  = 4'd9,
    S_DONE       = 4'd10,
    S_ERR        = 4'd11
  } state_e;

  // REG1/REG2 pairs for CLKOUT0, CLKOUT1 and CLKFBOUT, in processing order
  localparam logic [6:0] REG_ADDR [0:5] = '{7'h08, 7'h09, 7'h0A, 7'h0B, 7'h14, 7'h15};

  localparam logic [15:0] REG1_KEEP_MASK   = 16'hF000;
  localparam int          REG2_EDGE_BIT    = 7;
  localparam int          REG2_NOCOUNT_BIT = 6;

  localparam logic [6:0] FB_MULT_MAX = 7'd19;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DRDY_TO = 2'd1;
  localparam logic [1:0] ERR_LOCK_TO = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  // Returns {edge, nocount, high[5:0], low[5:0]} for a divide value d
  function automatic logic [13:0] div_to_hl(input logic [6:0] d);
    logic [5:0] high;
    logic [5:0] low;
    high = d[6:1];
    // low = d - high, only the six LSBs are ever written to the PLL
    low  = d[5:0] - high;
    if (d == 7'd1) begin
      high = 6'd1;
      low  = 6'd1;
    end
    return {d[0], (d == 7'd1), high, low};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_drp_port.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : pll_drp_port
// Brief  : Single DRP transaction engine: drives den/dwe for one cycle,
//          waits for drdy and flags a timeout if it never arrives.
// Rev    : 1.0 - initial release
// ============================================================================
module pll_drp_port #(
  parameter int DRDY_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic        drp_drdy_i,
  input  logic [15:0] drp_do_i,
  output logic        den_o,
  output logic        dwe_o,
  output logic [15:0] rdata_o,
  output logic        ok_o,
  output logic        timeout_o
);

  localparam int              CW       = $clog2(DRDY_TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DRDY_TIMEOUT);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic          waiting_q;
  logic [CW-1:0] cnt_q;

  // req_i is a registered one-cycle pulse from the caller, so den/dwe are glitch-free
  assign den_o     = req_i;
  assign dwe_o     = req_i & we_i;
  assign rdata_o   = drp_do_i;
  // drdy outside an open transaction (stale or spurious) never reaches the caller
  assign ok_o      = waiting_q & drp_drdy_i;
  assign timeout_o = waiting_q & ~drp_drdy_i & (cnt_q == CNT_LAST);

  // Track the open transaction and count cycles since its den
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      waiting_q <= 1'b0;
      cnt_q     <= '0;
    end else if (req_i) begin
      waiting_q <= 1'b1;
      cnt_q     <= CNT_ONE;
    end else if (waiting_q) begin
      if (ok_o || timeout_o) begin
        waiting_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pll_drp_reconfig.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : pll_drp_reconfig
// Brief  : DRP master that holds the PLL in reset, read-modify-writes the six
//          clock divider registers, releases reset and waits for lock.
// Rev    : 1.0 - initial release
// ============================================================================
module pll_drp_reconfig #(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RST_HOLD     = 8
) (
  input  logic        drp_dclk,
  input  logic        free_run_rst,
  input  logic        cfg_req,
  output logic        cfg_ack,
  input  logic [6:0]  cfg_out0_div,
  input  logic [6:0]  cfg_out1_div,
  input  logic [6:0]  cfg_fb_mult,
  output logic [6:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  output logic        drp_den,
  output logic        drp_dwe,
  input  logic        drp_drdy,
  input  logic        locked,
  output logic        pll_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  import pll_drp_pkg::*;

  localparam int            LW        = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);
  localparam int            HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  state_e        state_q;
  logic [2:0]    idx_q;
  logic [6:0]    out0_q, out1_q, fb_q;
  logic [6:0]    daddr_q;
  logic [15:0]   di_q;
  logic          req_q, we_q;
  logic [HW-1:0] hold_q;
  logic [LW-1:0] lock_cnt_q;
  logic          pll_rst_q, done_q, err_q, abort_q;
  logic [1:0]    err_code_q;
  logic          lock_meta_q, lock_sync_q;

  logic          w_ok, w_to;
  logic [15:0]   w_rdata;
  logic          w_cfg_illegal;

  // Builds the write word for register idx from its read-back value
  function automatic logic [15:0] merge_word(input logic [15:0] rd, input logic [2:0] idx,
                                             input logic [6:0] o0, input logic [6:0] o1,
                                             input logic [6:0] fb);
    logic [6:0]  d;
    logic [13:0] enc;
    logic [15:0] w;
    case (idx[2:1])
      2'd0:    d = o0;
      2'd1:    d = o1;
      default: d = fb;
    endcase
    enc = div_to_hl(d);
    if (!idx[0]) begin
      w = (rd & REG1_KEEP_MASK) | {4'b0000, enc[11:0]};
    end else begin
      w = rd;
      w[REG2_EDGE_BIT]    = enc[13];
      w[REG2_NOCOUNT_BIT] = enc[12];
    end
    return w;
  endfunction

  assign w_cfg_illegal = (cfg_out0_div == 7'd0) || (cfg_out1_div == 7'd0) ||
                         (cfg_fb_mult == 7'd0) || (cfg_fb_mult > FB_MULT_MAX);

  assign cfg_ack   = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign drp_daddr = daddr_q;
  assign drp_di    = di_q;
  assign pll_rst   = pll_rst_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

  pll_drp_port #(
    .DRDY_TIMEOUT (DRDY_TIMEOUT)
  ) u_port (
    .clk_i      (drp_dclk),
    .rst_i      (free_run_rst),
    .req_i      (req_q),
    .we_i       (we_q),
    .drp_drdy_i (drp_drdy),
    .drp_do_i   (drp_do),
    .den_o      (drp_den),
    .dwe_o      (drp_dwe),
    .rdata_o    (w_rdata),
    .ok_o       (w_ok),
    .timeout_o  (w_to)
  );

  // Two-flop synchronizer for the PLL lock indication
  always_ff @(posedge drp_dclk) begin
    if (free_run_rst) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  // Reconfiguration sequencer with registered outputs
  always_ff @(posedge drp_dclk) begin
    if (free_run_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      out0_q     <= 7'd0;
      out1_q     <= 7'd0;
      fb_q       <= 7'd0;
      daddr_q    <= 7'd0;
      di_q       <= 16'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      hold_q     <= '0;
      lock_cnt_q <= '0;
      pll_rst_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      req_q  <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_req) begin
            out0_q  <= cfg_out0_div;
            out1_q  <= cfg_out1_div;
            fb_q    <= cfg_fb_mult;
            idx_q   <= 3'd0;
            abort_q <= 1'b0;
            if (w_cfg_illegal) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_ILLEGAL;
              state_q    <= S_ERR;
            end else begin
              err_q      <= 1'b0;
              err_code_q <= ERR_NONE;
              pll_rst_q  <= 1'b1;
              state_q    <= S_ASSERT_RST;
            end
          end
        end
        S_ASSERT_RST: begin
          daddr_q <= REG_ADDR[idx_q];
          req_q   <= 1'b1;
          state_q <= S_RD;
        end
        S_RD: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (w_ok) begin
            di_q    <= merge_word(w_rdata, idx_q, out0_q, out1_q, fb_q);
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            state_q <= S_WR;
          end else if (w_to) begin
            err_code_q <= ERR_DRDY_TO;
            abort_q    <= 1'b1;
            hold_q     <= '0;
            state_q    <= S_HOLD;
          end
        end
        S_WR: state_q <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (w_ok) begin
            state_q <= S_NEXT;
          end else if (w_to) begin
            err_code_q <= ERR_DRDY_TO;
            abort_q    <= 1'b1;
            hold_q     <= '0;
            state_q    <= S_HOLD;
          end
        end
        S_NEXT: begin
          if (idx_q < 3'd5) begin
            idx_q   <= idx_q + 3'd1;
            daddr_q <= REG_ADDR[idx_q + 3'd1];
            req_q   <= 1'b1;
            state_q <= S_RD;
          end else begin
            hold_q  <= '0;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            pll_rst_q <= 1'b0;
            if (abort_q) begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end else begin
              state_q <= S_RELEASE;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        S_RELEASE: begin
          lock_cnt_q <= '0;
          state_q    <= S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_sync_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (lock_cnt_q == LOCK_LAST) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_LOCK_TO;
            state_q    <= S_ERR;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_drp_reconfig.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_pll_drp_reconfig
// Brief  : Self-checking bench for pll_drp_reconfig with a DRP slave / PLL
//          lock model and an arithmetic reference for the expected writes.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pll_drp_reconfig;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_req;
  logic        cfg_ack;
  logic [6:0]  cfg_out0_div, cfg_out1_div, cfg_fb_mult;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_den, drp_dwe, drp_drdy;
  logic        locked;
  logic        pll_rst, busy, done, err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;

  // DRP slave and PLL model state
  logic [15:0] mem [0:127];
  logic [6:0]  wr_addr [$];
  logic [15:0] wr_data [$];
  int          lat        = 1;
  int          lock_delay = 10;
  bit          lock_en    = 1'b1;
  int          drop_read_n = 0;
  int          read_idx   = 0;
  int          drop_den_cyc = 0;
  int          pend       = 0;
  logic [15:0] pend_data  = 16'h0;
  int          lk_cnt     = 0;
  int          den_cnt    = 0;
  int          done_cnt   = 0;
  bit          rst_seen   = 1'b0;
  int          cyc        = 0;
  int          addrs [6]  = '{8, 9, 10, 11, 20, 21};

  always #5 clk = ~clk;

  pll_drp_reconfig dut (
    .drp_dclk     (clk),
    .free_run_rst (rst),
    .cfg_req      (cfg_req),
    .cfg_ack      (cfg_ack),
    .cfg_out0_div (cfg_out0_div),
    .cfg_out1_div (cfg_out1_div),
    .cfg_fb_mult  (cfg_fb_mult),
    .drp_daddr    (drp_daddr),
    .drp_di       (drp_di),
    .drp_do       (drp_do),
    .drp_den      (drp_den),
    .drp_dwe      (drp_dwe),
    .drp_drdy     (drp_drdy),
    .locked       (locked),
    .pll_rst      (pll_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected DRP write word for register slot idx, divide d, read-back rd
  function automatic logic [15:0] ref_word(input int idx, input int d, input logic [15:0] rd);
    int hi, lo;
    if (d == 1) begin
      hi = 1; lo = 1;
    end else begin
      hi = d / 2; lo = d - hi;
    end
    if (idx % 2 == 0)
      return (rd & 16'hF000) | 16'(((hi % 64) * 64) + (lo % 64));
    else
      return (rd & 16'hFF3F) | 16'((d % 2) * 128) | 16'((d == 1) ? 64 : 0);
  endfunction

  // DRP slave and PLL lock behaviour, evaluated mid-cycle
  always @(negedge clk) begin
    cyc++;
    drp_drdy = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drp_drdy = 1'b1;
        drp_do   = pend_data;
      end
    end
    if (drp_dwe) chk("dwe_with_den", drp_den, 1);
    if (drp_den) begin
      den_cnt++;
      if (drp_dwe) begin
        chk("rst_during_wr", pll_rst, 1);
        wr_addr.push_back(drp_daddr);
        wr_data.push_back(drp_di);
        mem[drp_daddr] = drp_di;
        pend      = lat;
        pend_data = 16'h0;
      end else begin
        read_idx++;
        if (read_idx == drop_read_n) begin
          drop_den_cyc = cyc;
        end else begin
          pend      = lat;
          pend_data = mem[drp_daddr];
        end
      end
    end
    if (pll_rst) rst_seen = 1'b1;
    if (done) done_cnt++;
    if (pll_rst) begin
      lk_cnt = 0;
      locked = 1'b0;
    end else if (lock_en) begin
      if (lk_cnt < lock_delay) lk_cnt++;
      else locked = 1'b1;
    end else begin
      locked = 1'b0;
    end
  end

  task automatic do_req(input int o0, input int o1, input int fb);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    cfg_out0_div = 7'(o0);
    cfg_out1_div = 7'(o1);
    cfg_fb_mult  = 7'(fb);
    cfg_req      = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (cfg_ack) begin
        @(posedge clk); #1;
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    cfg_req = 1'b0;
    chk("req_accepted", acc, 1);
  endtask

  task automatic wait_end(input int budget, output bit to);
    to = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_legal(input int o0, input int o1, input int fb);
    logic [15:0] exp_w [6];
    int ds [3];
    bit to;
    ds = '{o0, o1, fb};
    for (int i = 0; i < 6; i++) exp_w[i] = ref_word(i, ds[i / 2], mem[addrs[i]]);
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    do_req(o0, o1, fb);
    wait_end(3000, to);
    chk("legal_no_timeout", to, 0);
    repeat (2) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("legal_err", err, 0);
    chk("legal_err_code", err_code, 0);
    chk("legal_pll_rst", pll_rst, 0);
    chk("legal_busy", busy, 0);
    chk("legal_ack", cfg_ack, 1);
    chk("wr_count", wr_addr.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_addr.size()) begin
        chk("wr_addr", wr_addr[i], addrs[i]);
        chk("wr_data", wr_data[i], exp_w[i]);
      end
    end
  endtask

  task automatic run_illegal(input int o0, input int o1, input int fb);
    bit to;
    den_cnt  = 0;
    rst_seen = 1'b0;
    do_req(o0, o1, fb);
    wait_end(50, to);
    chk("illegal_no_timeout", to, 0);
    repeat (2) @(negedge clk);
    chk("illegal_err", err, 1);
    chk("illegal_err_code", err_code, 3);
    chk("illegal_no_den", den_cnt, 0);
    chk("illegal_no_pll_rst", rst_seen, 0);
    chk("illegal_busy", busy, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] tmp;
    bit          to, seen_hi, got_err;
    int          rel_cyc, err_cyc, den_snap, t0;

    rst = 1'b1; cfg_req = 1'b0;
    cfg_out0_div = 7'd0; cfg_out1_div = 7'd0; cfg_fb_mult = 7'd0;
    drp_drdy = 1'b0; drp_do = 16'h0; locked = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", cfg_ack, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_pll_rst", pll_rst, 0);
    chk("rst_den", drp_den, 0);
    chk("rst_daddr", drp_daddr, 0);
    chk("rst_di", drp_di, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed: all divides 10
    mem[8'h08] = 16'hF000; mem[8'h09] = 16'h0000;
    lat = 3; lock_delay = 50; lock_en = 1'b1;
    run_legal(10, 10, 10);
    if (wr_data.size() >= 2) begin
      chk("t1_w08", wr_data[0], 16'hF145);
      chk("t1_w09", wr_data[1], 16'h0000);
    end

    // Directed: odd divide on CLKOUT0 sets edge, keeps other bits
    mem[8'h09] = 16'h1234;
    run_legal(7, 10, 10);
    if (wr_data.size() >= 2) begin
      tmp = wr_data[0];
      chk("t2_w08_hl", tmp[11:0], 12'h0C4);
      chk("t2_w09", wr_data[1], 16'h12B4);
    end

    // Directed: divide of 1 on CLKOUT1
    run_legal(10, 1, 10);
    if (wr_data.size() >= 4) begin
      tmp = wr_data[2];
      chk("t3_w0a_hl", tmp[11:0], 12'h041);
      tmp = wr_data[3];
      chk("t3_w0b_nocount", tmp[6], 1);
    end

    // Randomized legal configurations
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 6; i++) mem[addrs[i]] = 16'($urandom);
      lat = $urandom_range(1, 6);
      lock_delay = $urandom_range(1, 40);
      run_legal($urandom_range(1, 127), $urandom_range(1, 127), $urandom_range(1, 19));
    end

    // Illegal configurations
    run_illegal(10, 10, 20);
    run_illegal(0, 5, 5);
    run_illegal(5, 0, 5);

    // drdy withheld on the third read (0x0A)
    lat = 2; read_idx = 0; drop_den_cyc = 0; drop_read_n = 3;
    do_req(10, 10, 10);
    for (int k = 0; k < 300 && drop_den_cyc == 0; k++) @(negedge clk);
    chk("drop_read_seen", (drop_den_cyc != 0), 1);
    repeat (70) @(negedge clk);
    chk("drdy_to_rst_held", pll_rst, 1);
    chk("drdy_to_code_early", err_code, 1);
    repeat (10) @(negedge clk);
    chk("drdy_to_rst_released", pll_rst, 0);
    chk("drdy_to_err", err, 1);
    chk("drdy_to_code", err_code, 1);
    chk("drdy_to_busy", busy, 0);
    drop_read_n = 0;
    repeat (5) @(negedge clk);
    run_legal(12, 33, 8);

    // Lock never arrives
    lat = 1; lock_en = 1'b0;
    do_req(10, 10, 10);
    seen_hi = 1'b0; rel_cyc = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (pll_rst) seen_hi = 1'b1;
      else if (seen_hi) begin
        rel_cyc = cyc;
        break;
      end
    end
    chk("lock_to_release_seen", (rel_cyc != 0), 1);
    got_err = 1'b0; err_cyc = 0;
    for (int k = 0; k < 70000; k++) begin
      @(negedge clk);
      if (err) begin
        got_err = 1'b1;
        err_cyc = cyc;
        break;
      end
    end
    chk("lock_to_err", got_err, 1);
    chk("lock_to_window", ((err_cyc - rel_cyc) >= 65534) && ((err_cyc - rel_cyc) <= 65539), 1);
    chk("lock_to_code", err_code, 2);
    lock_en = 1'b1;
    repeat (3) @(negedge clk);

    // free_run_rst while waiting for a write acknowledge
    lat = 10; done_cnt = 0;
    do_req(10, 10, 10);
    to = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (drp_den && drp_dwe) begin
        to = 1'b0;
        break;
      end
    end
    chk("frr_write_seen", to, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("frr_busy", busy, 0);
    chk("frr_pll_rst", pll_rst, 0);
    chk("frr_ack", cfg_ack, 1);
    den_snap = den_cnt;
    t0 = cyc;
    repeat (15) @(negedge clk);
    chk("frr_stale_busy", busy, 0);
    chk("frr_stale_no_den", den_cnt - den_snap, 0);
    chk("frr_stale_no_done", done_cnt, 0);
    chk("frr_stale_err", err, 0);
    lat = 1;
    run_legal(3, 4, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
